// File: rtl/img_pkg.sv
// Shared types and constants for the image windowing pipeline.
//   PIX_W  pixel width
//   WIN_W  flattened 3x3 window width
//   CNT_W  row/column counter width
//   SUM_W  width of the optional 9-pixel sum
// win_pack() flattens a window so that p00 (oldest row, leftmost column)
// lands in the top byte and p22 (newest row, rightmost column) in the
// bottom byte.
package img_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 72;
    localparam int CNT_W = 10;
    localparam int SUM_W = 12;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [2:0][2:0]  win_t;   // [row 0=oldest][col 0=left]
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic [WIN_W-1:0] win_pack(input win_t w);
        logic [WIN_W-1:0] flat;
        flat = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                flat[WIN_W-1-(i*3+j)*PIX_W -: PIX_W] = w[i][j];
            end
        end
        return flat;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row pixel store: one write port, one registered read port.
// Read-before-write on a shared address; written so it maps to block RAM.
// The contents are never reset.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address (column)
//   wr_data  pixel to store
//   rd_addr  read address, sampled on the clock edge
//   rd_data  registered read data (contents of rd_addr before this edge's write)
module line_buffer
    import img_pkg::*;
#(
    parameter int DEPTH = 540,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pix_t          wr_data,
    input  logic [AW-1:0] rd_addr,
    output pix_t          rd_data
);

    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator for a raster-order 8-bit pixel stream.
// Two line buffers hold the previous two rows; each accepted pixel shifts
// the column {row r-2, row r-1, row r} into a 3x3 register window. A window
// is emitted one cycle after accepting pixel (r,c) with r>=2 and c>=2, and
// its centre is (r-1,c-1).
// Optional feature macro: WIN_SUM_EN adds win_sum_o (sum of the 9 pixels).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clear_i         synchronous frame restart (wins over data_en_i)
//   data_i          pixel, qualified by data_en_i
//   data_en_i       pixel accept strobe (may stall any cycle)
//   win_o           3x3 window, p00 at [71:64] ... p22 at [7:0]
//   win_valid_o     one-cycle window strobe
//   win_row_o       window centre row
//   win_col_o       window centre column
//   frame_done_o    pulse with the window of the last pixel of the frame
//   win_sum_o       9-pixel sum (WIN_SUM_EN only)
module window_3x3_gen
    import img_pkg::*;
#(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [PIX_W-1:0] data_i,
    input  logic             data_en_i,
    output logic [WIN_W-1:0] win_o,
    output logic             win_valid_o,
    output logic [CNT_W-1:0] win_row_o,
    output logic [CNT_W-1:0] win_col_o,
    output logic             frame_done_o
`ifdef WIN_SUM_EN
    ,
    output logic [SUM_W-1:0] win_sum_o
`endif
);

    localparam int   AW       = $clog2(MAX_COL);
    localparam cnt_t ROW_LAST = cnt_t'(MAX_ROW - 1);
    localparam cnt_t COL_LAST = cnt_t'(MAX_COL - 1);

    cnt_t row, col;
    cnt_t row_next, col_next;
    logic accept;
    logic take_win;
    pix_t lb0_q, lb1_q;

    win_t win_p1;
    logic vld_p1;
    logic done_p1;
    cnt_t crow_p1, ccol_p1;

    assign accept   = rst_n && !clear_i && data_en_i;
    assign take_win = accept && (row >= cnt_t'(2)) && (col >= cnt_t'(2));

    // Next raster position. The line buffers are addressed with this value so
    // their registered read already holds column c when pixel (r,c) arrives.
    always_comb begin
        row_next = row;
        col_next = col;
        if (!rst_n || clear_i) begin
            row_next = '0;
            col_next = '0;
        end else if (data_en_i) begin
            if (col == COL_LAST) begin
                col_next = '0;
                row_next = (row == ROW_LAST) ? '0 : row + cnt_t'(1);
            end else begin
                col_next = col + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        row <= row_next;
        col <= col_next;
    end

    // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old value.
    line_buffer #(.DEPTH(MAX_COL), .AW(AW)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (col[AW-1:0]),
        .wr_data (data_i),
        .rd_addr (col_next[AW-1:0]),
        .rd_data (lb0_q)
    );

    line_buffer #(.DEPTH(MAX_COL), .AW(AW)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (col[AW-1:0]),
        .wr_data (lb0_q),
        .rd_addr (col_next[AW-1:0]),
        .rd_data (lb1_q)
    );

    // ---- stage p1: window registers, strobes and centre coordinates ----
    // Stale columns from the previous row are not flushed; the c>=2 gate
    // keeps them from ever appearing in a valid window.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            win_p1  <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            crow_p1 <= '0;
            ccol_p1 <= '0;
        end else begin
            vld_p1  <= take_win;
            done_p1 <= accept && (row == ROW_LAST) && (col == COL_LAST);
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win_p1[i][0] <= win_p1[i][1];
                    win_p1[i][1] <= win_p1[i][2];
                end
                win_p1[0][2] <= lb1_q;
                win_p1[1][2] <= lb0_q;
                win_p1[2][2] <= data_i;
            end
            if (take_win) begin
                crow_p1 <= row - cnt_t'(1);
                ccol_p1 <= col - cnt_t'(1);
            end
        end
    end

    assign win_o        = win_pack(win_p1);
    assign win_valid_o  = vld_p1;
    assign win_row_o    = crow_p1;
    assign win_col_o    = ccol_p1;
    assign frame_done_o = done_p1;

`ifdef WIN_SUM_EN
    logic [SUM_W-1:0] sum_next;
    logic [SUM_W-1:0] sum_p1;

    // Sum of the window as it will look after this cycle's shift.
    always_comb begin
        sum_next = SUM_W'(lb1_q) + SUM_W'(lb0_q) + SUM_W'(data_i);
        for (int i = 0; i < 3; i++) begin
            sum_next = sum_next + SUM_W'(win_p1[i][1]) + SUM_W'(win_p1[i][2]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            sum_p1 <= '0;
        end else if (accept) begin
            sum_p1 <= sum_next;
        end
    end

    assign win_sum_o = sum_p1;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized self-checking bench for window_3x3_gen (MAX_ROW=4, MAX_COL=5).
// The reference keeps the current frame as a plain 2-D pixel array and
// derives each expected window directly from the image coordinates.
module tb_window_3x3_gen;
    import img_pkg::*;

    localparam int MR = 4;
    localparam int MC = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [PIX_W-1:0] data = '0;
    logic             data_en = 1'b0;
    logic [WIN_W-1:0] win;
    logic             win_valid;
    logic [CNT_W-1:0] win_row, win_col;
    logic             frame_done;
`ifdef WIN_SUM_EN
    logic [SUM_W-1:0] win_sum;
`endif

    window_3x3_gen #(.MAX_ROW(MR), .MAX_COL(MC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear),
        .data_i       (data),
        .data_en_i    (data_en),
        .win_o        (win),
        .win_valid_o  (win_valid),
        .win_row_o    (win_row),
        .win_col_o    (win_col),
        .frame_done_o (frame_done)
`ifdef WIN_SUM_EN
        ,
        .win_sum_o    (win_sum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    int img [MR][MC];
    int mr = 0, mc = 0;
    bit hold_ok = 0;
    logic [WIN_W-1:0] last_win;
    int last_r, last_c;
    int dut_wins, dut_dones;
    bit first_seen;
    logic [WIN_W-1:0] first_win;

    task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, then check outputs 1 time unit after the edge.
    task automatic step(input logic en, input logic clr, input logic rstn, input logic [7:0] d);
        logic [WIN_W-1:0] ew;
        int esum;
        data_en = en; clear = clr; rst_n = rstn; data = d;
        @(posedge clk); #1;
        if (win_valid) dut_wins++;
        if (frame_done) dut_dones++;
        if (!rstn || clr) begin
            mr = 0; mc = 0; hold_ok = 0;
            chk("clr_win", win, '0);
            chk("clr_vld", WIN_W'(win_valid), '0);
            chk("clr_row", WIN_W'(win_row), '0);
            chk("clr_col", WIN_W'(win_col), '0);
            chk("clr_done", WIN_W'(frame_done), '0);
`ifdef WIN_SUM_EN
            chk("clr_sum", WIN_W'(win_sum), '0);
`endif
        end else if (en) begin
            img[mr][mc] = int'(d);
            if (mr >= 2 && mc >= 2) begin
                ew = '0; esum = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        ew = (ew << 8) | WIN_W'(img[mr-2+i][mc-2+j]);
                        esum += img[mr-2+i][mc-2+j];
                    end
                chk("win_vld", WIN_W'(win_valid), WIN_W'(1));
                chk("win_data", win, ew);
                chk("win_row", WIN_W'(win_row), WIN_W'(mr-1));
                chk("win_col", WIN_W'(win_col), WIN_W'(mc-1));
                chk("win_done", WIN_W'(frame_done), WIN_W'(mr == MR-1 && mc == MC-1));
`ifdef WIN_SUM_EN
                chk("win_sum", WIN_W'(win_sum), WIN_W'(esum));
`endif
                if (win_valid && !first_seen) begin
                    first_seen = 1; first_win = win;
                end
                hold_ok = 1; last_win = ew; last_r = mr-1; last_c = mc-1;
            end else begin
                chk("border_vld", WIN_W'(win_valid), '0);
                chk("border_done", WIN_W'(frame_done), '0);
                hold_ok = 0;
            end
            mc++;
            if (mc == MC) begin
                mc = 0; mr++;
                if (mr == MR) mr = 0;
            end
        end else begin
            chk("gap_vld", WIN_W'(win_valid), '0);
            chk("gap_done", WIN_W'(frame_done), '0);
            if (hold_ok) begin
                chk("gap_win_hold", win, last_win);
                chk("gap_row_hold", WIN_W'(win_row), WIN_W'(last_r));
                chk("gap_col_hold", WIN_W'(win_col), WIN_W'(last_c));
            end
        end
    endtask

    // Feed n pixels from the current position; value is row*16+col or random.
    task automatic feed(input int n, input bit rnd_data, input bit gaps);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = rnd_data ? 8'($urandom) : 8'(mr*16 + mc);
            step(1'b1, 1'b0, 1'b1, d);
            if (gaps && $urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                    step(1'b0, 1'b0, 1'b1, 8'($urandom));
            end
        end
    endtask

    task automatic start_count();
        dut_wins = 0; dut_dones = 0; first_seen = 0;
    endtask

    initial begin
        // reset
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h55);

        // 1: continuous pattern frame
        start_count();
        feed(MR*MC, 1'b0, 1'b0);
        chk("t1_wins", WIN_W'(dut_wins), WIN_W'(6));
        chk("t1_dones", WIN_W'(dut_dones), WIN_W'(1));
        chk("t1_first", first_win, 72'h00_01_02_10_11_12_20_21_22);

        // 3: pattern frame with stalls
        start_count();
        feed(MR*MC, 1'b0, 1'b1);
        chk("t3_wins", WIN_W'(dut_wins), WIN_W'(6));

        // 4: two back-to-back random frames
        start_count();
        feed(2*MR*MC, 1'b1, 1'b1);
        chk("t4_wins", WIN_W'(dut_wins), WIN_W'(12));
        chk("t4_dones", WIN_W'(dut_dones), WIN_W'(2));

        // 5: clear after pixel (2,3) while a pixel is offered
        feed(2*MC + 4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hAA);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        start_count();
        feed(MR*MC, 1'b0, 1'b1);
        chk("t5_wins", WIN_W'(dut_wins), WIN_W'(6));
        chk("t5_first", first_win, 72'h00_01_02_10_11_12_20_21_22);

        // 6: reset mid row 3, then fresh frame
        feed(3*MC + 2, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h33);
        start_count();
        feed(MR*MC, 1'b0, 1'b0);
        chk("t6_wins", WIN_W'(dut_wins), WIN_W'(6));
        chk("t6_dones", WIN_W'(dut_dones), WIN_W'(1));
        chk("t6_first", first_win, 72'h00_01_02_10_11_12_20_21_22);

        // extra random frames with stalls and random data
        start_count();
        feed(3*MR*MC, 1'b1, 1'b1);
        chk("rnd_wins", WIN_W'(dut_wins), WIN_W'(18));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
